// File: rtl/traffic_ctrl.sv
// Two-road intersection controller: main road, side road and a pedestrian crossing.
// Requests are latched, each phase has its own dwell time, and all-red separates conflicts.
module traffic_ctrl #(
   parameter int CNT_W      = 8,
   parameter int MIN_GREEN  = 4,
   parameter int GREEN_CYC  = 8,
   parameter int YELLOW_CYC = 3,
   parameter int ALLRED_CYC = 2,
   parameter int PED_CYC    = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       side_req,
   input  logic       ped_req,
   output logic [1:0] main_light,
   output logic [1:0] side_light,
   output logic       walk,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      ST_MAIN_G   = 3'd0,
      ST_MAIN_Y   = 3'd1,
      ST_ALLRED_A = 3'd2,
      ST_SIDE_G   = 3'd3,
      ST_SIDE_Y   = 3'd4,
      ST_ALLRED_B = 3'd5,
      ST_WALK     = 3'd6
   } state_t;

   localparam logic [1:0] LAMP_G = 2'b00;
   localparam logic [1:0] LAMP_Y = 2'b01;
   localparam logic [1:0] LAMP_R = 2'b10;

   // Terminal counts: a phase of duration D exits on the edge where the counter reads D-1.
   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_CYC - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             r_side_pend;
   logic             r_ped_pend;
   logic             w_side_pend_next;
   logic             w_ped_pend_next;
   logic             w_state_chg;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_MAIN_G;
         r_cnt       <= '0;
         r_side_pend <= 1'b0;
         r_ped_pend  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_side_pend <= w_side_pend_next;
         r_ped_pend  <= w_ped_pend_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_MAIN_G: begin
            if (r_cnt == MIN_LAST && (r_side_pend || r_ped_pend))
               w_state_next = ST_MAIN_Y;
         end
         ST_MAIN_Y: begin
            if (r_cnt == YEL_LAST)
               w_state_next = ST_ALLRED_A;
         end
         ST_ALLRED_A: begin
            if (r_cnt == AR_LAST) begin
               if (r_side_pend)
                  w_state_next = ST_SIDE_G;
               else if (r_ped_pend)
                  w_state_next = ST_WALK;
               else
                  w_state_next = ST_MAIN_G;
            end
         end
         ST_SIDE_G: begin
            if (r_cnt == GRN_LAST)
               w_state_next = ST_SIDE_Y;
         end
         ST_SIDE_Y: begin
            if (r_cnt == YEL_LAST)
               w_state_next = ST_ALLRED_B;
         end
         ST_ALLRED_B: begin
            if (r_cnt == AR_LAST)
               w_state_next = r_ped_pend ? ST_WALK : ST_MAIN_G;
         end
         ST_WALK: begin
            if (r_cnt == PED_LAST)
               w_state_next = ST_MAIN_G;
         end
         default: w_state_next = ST_MAIN_G;
      endcase
   end

   assign w_state_chg = (w_state_next != r_state);

   // Main green parks at its terminal count so a late request is served immediately.
   always_comb begin
      w_cnt_next = r_cnt + 1'b1;
      if (w_state_chg)
         w_cnt_next = '0;
      else if (r_state == ST_MAIN_G && r_cnt >= MIN_LAST)
         w_cnt_next = r_cnt;
   end

   // A request arriving on the edge that starts its own service is absorbed by that service.
   always_comb begin
      w_side_pend_next = r_side_pend | (side_req & (r_state != ST_SIDE_G));
      w_ped_pend_next  = r_ped_pend  | (ped_req  & (r_state != ST_WALK));
      if (w_state_next == ST_SIDE_G && r_state != ST_SIDE_G)
         w_side_pend_next = 1'b0;
      if (w_state_next == ST_WALK && r_state != ST_WALK)
         w_ped_pend_next = 1'b0;
   end

   always_comb begin
      main_light = LAMP_R;
      side_light = LAMP_R;
      walk       = 1'b0;
      case (r_state)
         ST_MAIN_G: main_light = LAMP_G;
         ST_MAIN_Y: main_light = LAMP_Y;
         ST_SIDE_G: side_light = LAMP_G;
         ST_SIDE_Y: side_light = LAMP_Y;
         ST_WALK:   walk       = 1'b1;
         default: ;
      endcase
   end

   assign phase = r_state;

   a_roads_exclusive: assert property (@(posedge clk)
      !(main_light != LAMP_R && side_light != LAMP_R));
   a_walk_all_red: assert property (@(posedge clk)
      walk |-> (main_light == LAMP_R && side_light == LAMP_R));

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: a per-cycle vector table, directed corner sequences, and
// random traffic compared against a phase-schedule reference model.
module tb_traffic_ctrl;

   localparam int CNT_W      = 8;
   localparam int MIN_GREEN  = 4;
   localparam int GREEN_CYC  = 8;
   localparam int YELLOW_CYC = 3;
   localparam int ALLRED_CYC = 2;
   localparam int PED_CYC    = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       side_req = 1'b0;
   logic       ped_req = 1'b0;
   logic [1:0] main_light;
   logic [1:0] side_light;
   logic       walk;
   logic [2:0] phase;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   traffic_ctrl #(
      .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .GREEN_CYC(GREEN_CYC),
      .YELLOW_CYC(YELLOW_CYC), .ALLRED_CYC(ALLRED_CYC), .PED_CYC(PED_CYC)
   ) dut (
      .clk(clk), .reset(reset), .side_req(side_req), .ped_req(ped_req),
      .main_light(main_light), .side_light(side_light), .walk(walk), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       s;
      logic       p;
      logic [2:0] ph;
      logic [1:0] ml;
      logic [1:0] sl;
      logic       w;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [1:0] main_of(input int ph);
      return (ph == 0) ? 2'b00 : (ph == 1) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] side_of(input int ph);
      return (ph == 3) ? 2'b00 : (ph == 4) ? 2'b01 : 2'b10;
   endfunction

   task automatic add(input logic r, input logic s, input logic p, input int ph);
      vec_t v;
      v.rst = r; v.s = s; v.p = p; v.ph = 3'(ph);
      v.ml = main_of(ph); v.sl = side_of(ph); v.w = (ph == 6);
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic s, input logic p);
      @(negedge clk);
      reset = r; side_req = s; ped_req = p;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic check(input string nm, input logic [2:0] ph, input logic [1:0] ml,
                        input logic [1:0] sl, input logic w);
      n_checks++;
      if (phase !== ph || main_light !== ml || side_light !== sl || walk !== w) begin
         n_errors++;
         $display("FAIL %s cyc=%0d: got phase=%0d main=%b side=%b walk=%b, want phase=%0d main=%b side=%b walk=%b",
                  nm, cyc, phase, main_light, side_light, walk, ph, ml, sl, w);
      end
   endtask

   task automatic run(input int ph, input int n, input logic s, input logic p, input string nm);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, s, p);
         check(nm, 3'(ph), main_of(ph), side_of(ph), ph == 6);
      end
   endtask

   task automatic do_reset(input string nm);
      drive(1'b1, 1'b0, 1'b0);
      check(nm, 3'd0, 2'b00, 2'b10, 1'b0);
   endtask

   // Reference model: a queue of upcoming per-cycle phases, refilled with a whole
   // segment whenever a decision point is reached.
   int  m_q[$];
   int  m_cur = 0;
   int  m_green = 1;
   bit  m_sp = 0;
   bit  m_pp = 0;

   task automatic push_seg(input int ph, input int n);
      for (int i = 0; i < n; i++) m_q.push_back(ph);
   endtask

   task automatic model_step(input bit r, input bit s, input bit p);
      int nxt;
      bit osp;
      bit opp;
      if (r) begin
         m_q.delete(); m_cur = 0; m_green = 1; m_sp = 0; m_pp = 0;
         return;
      end
      osp = m_sp;
      opp = m_pp;
      if (m_cur != 3 && s) m_sp = 1;
      if (m_cur != 6 && p) m_pp = 1;
      nxt = 0;
      if (m_q.size() > 0) begin
         nxt = m_q.pop_front();
      end else begin
         case (m_cur)
            0: if (m_green >= MIN_GREEN && (osp || opp)) begin
                  nxt = 1; push_seg(1, YELLOW_CYC - 1); push_seg(2, ALLRED_CYC);
               end
            2: if (osp) begin
                  nxt = 3; push_seg(3, GREEN_CYC - 1); push_seg(4, YELLOW_CYC); push_seg(5, ALLRED_CYC);
               end else if (opp) begin
                  nxt = 6; push_seg(6, PED_CYC - 1);
               end
            5: if (opp) begin
                  nxt = 6; push_seg(6, PED_CYC - 1);
               end
            default: nxt = 0;
         endcase
      end
      if (nxt == 3 && m_cur != 3) m_sp = 0;
      if (nxt == 6 && m_cur != 6) m_pp = 0;
      m_green = (nxt == 0) ? ((m_cur == 0) ? m_green + 1 : 1) : 0;
      m_cur = nxt;
   endtask

   initial begin
      // Table: reset, idle, ped pulse, walk with extra pulses, then no retrigger.
      add(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0);
      add(0, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 1);
      for (int i = 0; i < 2; i++) add(0, 0, 0, 2);
      for (int i = 0; i < 6; i++) add(0, 0, (i == 1 || i == 3) ? 1'b1 : 1'b0, 6);
      for (int i = 0; i < 5; i++) add(0, 0, 0, 0);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].s, tbl[i].p);
         check("table", tbl[i].ph, tbl[i].ml, tbl[i].sl, tbl[i].w);
      end

      do_reset("idle_reset");
      run(0, 100, 0, 0, "idle_100");

      do_reset("side_pulse_reset");
      run(0, 9, 0, 0, "side_pulse_pre");
      run(0, 1, 1, 0, "side_pulse_edge");
      run(1, YELLOW_CYC, 0, 0, "side_pulse_main_y");
      run(2, ALLRED_CYC, 0, 0, "side_pulse_allred_a");
      run(3, GREEN_CYC, 0, 0, "side_pulse_side_g");
      run(4, YELLOW_CYC, 0, 0, "side_pulse_side_y");
      run(5, ALLRED_CYC, 0, 0, "side_pulse_allred_b");
      run(0, 8, 0, 0, "side_pulse_post");

      do_reset("side_held_reset");
      run(0, MIN_GREEN - 1, 1, 0, "side_held_min_green");
      run(1, YELLOW_CYC, 1, 0, "side_held_main_y");
      run(2, ALLRED_CYC, 1, 0, "side_held_allred_a");
      run(3, 2, 1, 0, "side_held_side_g_req");
      run(3, GREEN_CYC - 2, 0, 0, "side_held_side_g");
      run(4, YELLOW_CYC, 0, 0, "side_held_side_y");
      run(5, ALLRED_CYC, 0, 0, "side_held_allred_b");
      run(0, 10, 0, 0, "side_held_no_retrigger");

      do_reset("both_reset");
      run(0, 5, 0, 0, "both_pre");
      run(0, 1, 1, 1, "both_edge");
      run(1, YELLOW_CYC, 0, 0, "both_main_y");
      run(2, ALLRED_CYC, 0, 0, "both_allred_a");
      run(3, GREEN_CYC, 0, 0, "both_side_g");
      run(4, YELLOW_CYC, 0, 0, "both_side_y");
      run(5, ALLRED_CYC, 0, 0, "both_allred_b");
      run(6, PED_CYC, 0, 0, "both_walk");
      run(0, 10, 0, 0, "both_no_retrigger");

      do_reset("midreset_reset");
      run(0, 5, 0, 0, "midreset_pre");
      run(0, 1, 1, 0, "midreset_edge");
      run(1, YELLOW_CYC, 0, 0, "midreset_main_y");
      run(2, ALLRED_CYC, 0, 0, "midreset_allred_a");
      run(3, 3, 0, 1, "midreset_side_g");
      drive(1'b1, 1'b1, 1'b1);
      check("midreset_hit", 3'd0, 2'b00, 2'b10, 1'b0);
      run(0, 15, 0, 0, "midreset_no_stale");

      // Random traffic against the reference model.
      drive(1'b1, 1'b0, 1'b0);
      model_step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4000; i++) begin
         bit r;
         bit s;
         bit p;
         r = ($urandom_range(0, 399) == 0);
         s = ($urandom_range(0, 11) == 0);
         p = ($urandom_range(0, 13) == 0);
         drive(r, s, p);
         model_step(r, s, p);
         check("random", 3'(m_cur), main_of(m_cur), side_of(m_cur), m_cur == 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
